cla_accumulator: RTL
====================

CLA_ACCUMULATOR -- requirements
Module: cla_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 10, giving the signed accumulator width (ACC_W >= 10).
REQ-002 SHALL have parameter CNT_W, default 4, giving the frame-length field width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, indicating that the operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, indicating that the block can accept a pair.
REQ-007 SHALL have port a, input, 8 bits, signed operand A.
REQ-008 SHALL have port b, input, 8 bits, signed operand B.
REQ-009 SHALL have port len, input, CNT_W bits, giving the number of pairs per frame; the value 0 means 2^CNT_W pairs.
REQ-010 SHALL have port out_valid, output, 1 bit, indicating that the frame result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, indicating that the consumer accepts the result.
REQ-012 SHALL have port acc_out, output, ACC_W bits, the signed frame sum.
REQ-013 SHALL have port sat, output, 1 bit, set when any saturation occurred in the frame.

Function
REQ-014 SHALL form each pair sum a+b as a 9-bit signed value using one cla_8bit instance, with no other adder on that path.
REQ-015 SHALL sign-extend the 9-bit sum to ACC_W+1 bits before adding it to the accumulator.
REQ-016 SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE.
REQ-018 SHALL accept a beat only on a clock edge where in_valid=1 and in_ready=1.
REQ-019 SHALL, on a beat accepted in IDLE, start a new frame:
- latch len into an internal target register;
- load acc with the saturated sign-extended sum;
- set the beat count to 1;
- set sat only if that beat saturated;
- enter ACCUM, or enter DONE if the target is 1.
REQ-020 SHALL, on a beat accepted in ACCUM:
- update acc to sat(acc + sext(sum));
- increment the count;
- OR the saturation event into sat.
REQ-021 SHALL enter DONE on the edge that accepts the beat bringing the count equal to the target, so out_valid rises one cycle after the last beat is presented.
REQ-022 SHALL ignore changes on len after the first beat of a frame.
REQ-023 SHALL saturate as follows:
- a result above 2^(ACC_W-1)-1 is clamped to that value;
- a result below -2^(ACC_W-1) is clamped to that value;
- either clamp sets sat.
REQ-024 SHALL drive out_valid=1 only in DONE, and SHALL hold acc_out and sat stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on an edge in DONE with out_ready=1, return to IDLE and clear acc, the count and sat to 0.
REQ-026 SHALL NOT accept any input in the DONE cycle in which out_ready=1, even if in_valid=1; this gives a one-cycle bubble.
REQ-027 SHALL drive acc_out directly from the accumulator register, with no combinational path from a or b to acc_out.
REQ-028 SHALL keep the state unchanged in IDLE or ACCUM when in_valid=0.
REQ-029 SHALL hold the internal count at CNT_W+1 bits so that a target of 2^CNT_W is reachable.

Reset
REQ-030 SHALL, while rst=1, asynchronously force:
- state=IDLE;
- acc=0, count=0, target=0;
- sat=0, out_valid=0, in_ready=1, acc_out=0.
REQ-031 SHALL, on rst asserted mid-frame or in DONE, discard the partial frame, so the first beat after release starts a fresh frame.

Verification
REQ-032 SHALL be verified with len=3 and pairs (10,20), (-5,-7), (100,27): out_valid rises one cycle after the third beat, with acc_out=145 and sat=0.
REQ-033 SHALL be verified with len=4 and four pairs (127,127): acc_out=511 and sat=1; with len=3 and three pairs (-128,-128): acc_out=-512 and sat=1.
REQ-034 SHALL be verified with out_ready held 0 for 5 cycles in DONE while in_valid=1: acc_out and sat stay stable, in_ready=0, and no beat is accepted; after out_ready=1 for one edge the block is in IDLE with in_ready=1.
REQ-035 SHALL be verified with len=0 and 16 pairs (1,0): out_valid rises only after the 16th beat, with acc_out=16; len changed to 2 after beat 1 has no effect.
REQ-036 SHALL be verified with rst pulsed after 2 of 3 beats: all outputs go to reset values immediately; a new frame with len=1 and pair (3,4) then yields acc_out=7.
REQ-037 SHALL be verified with in_valid toggled 1,0,1,0,1 and len=3, pairs (1,1) each: exactly 3 beats are accepted and acc_out=6.

Source files
------------

// File: rtl/cla_accumulator.sv
// cla_accumulator: framed signed accumulator of a+b pairs with saturation, valid/ready in and out.
// Ports: clk, rst (async, active high); in_valid/in_ready with operands a, b (signed 8-bit)
// and len (pairs per frame, 0 = 2^CNT_W); out_valid/out_ready with acc_out (signed frame sum)
// and sat (a clamp occurred somewhere in the frame).
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] sum
);
    logic [7:0] g, p;
    logic [8:0] c;
    logic       t;
    assign g = a & b;
    assign p = a ^ b;
    // Flat lookahead: each carry is the OR of every generate propagated through all higher bits.
    always_comb begin
        c = '0;
        t = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
    end
    // Bit 8 is the true sign of the 9-bit signed sum, not the raw carry out.
    assign sum = {a[7] ^ b[7] ^ c[8], p ^ c[7:0]};
endmodule

module cla_accumulator #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [CNT_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, next;
    logic [ACC_W-1:0] acc, clamped;
    logic [CNT_W:0]   cnt, tgt, tgt_new, cnt_inc;
    logic [8:0]       sum9;
    logic [ACC_W:0]   base, ext, tot;
    logic             beat, last, ovf, sat_r;
    cla_8bit u_cla (.a(a), .b(b), .sum(sum9));
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign acc_out   = acc;
    assign sat       = sat_r;
    assign beat      = in_valid & in_ready;
    assign tgt_new   = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
    assign cnt_inc   = cnt + 1'b1;
    assign last      = (state == IDLE) ? (tgt_new == (CNT_W+1)'(1)) : (cnt_inc == tgt);
    // A new frame starts from zero rather than the (already cleared) register.
    assign base      = (state == IDLE) ? '0 : {acc[ACC_W-1], acc};
    assign ext       = {{(ACC_W-8){sum9[8]}}, sum9};
    assign tot       = base + ext;
    // One guard bit suffices: sign disagreement between the top two bits means overflow.
    assign ovf       = tot[ACC_W] ^ tot[ACC_W-1];
    assign clamped   = ovf ? (tot[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                           : tot[ACC_W-1:0];
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;
    always_comb begin
        next = state;
        if (state == DONE) next = out_ready ? IDLE : DONE;
        else if (beat)     next = last ? DONE : ACCUM;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            tgt   <= '0;
            sat_r <= 1'b0;
        end else if (state == DONE) begin
            if (out_ready) begin
                acc   <= '0;
                cnt   <= '0;
                sat_r <= 1'b0;
            end
        end else if (beat) begin
            acc   <= clamped;
            cnt   <= (state == IDLE) ? (CNT_W+1)'(1) : cnt_inc;
            sat_r <= ovf | ((state == ACCUM) & sat_r);
            if (state == IDLE) tgt <= tgt_new;
        end
    end
endmodule
